load_store_unit: RTL and testbench

Sits between the pipeline's MEM stage and a variable-latency data memory. It replaces the single-cycle dmem connection with a request/acknowledge bus. It stalls the pipeline while an access is outstanding, generates byte enables and store-lane data, and returns load data byte-aligned so that the existing read-data extender only needs the low bits. It flags misaligned accesses and bus timeouts to exception handling.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_store_align.sv | 37 +++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment rule used to reject accesses before they reach the bus.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // Halves need an even address, words a 4-byte boundary; size 11 is never legal
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addrLo[0];
      SIZE_W:  bad = |addrLo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Store lane steering: turns right-aligned store data into bus lane data
// plus the byte enables that select the lanes actually written.
module store_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o
);

  // Replicate the low byte/half into every lane so the enables alone pick the target
  always_comb begin
    be_o   = 4'b0000;
    data_o = 32'h0;
    case (size_i)
      SIZE_B: begin
        be_o   = 4'b0001 << addrLo_i;
        data_o = {4{wdata_i[7:0]}};
      end
      SIZE_H: begin
        be_o   = addrLo_i[1] ? 4'b1100 : 4'b0011;
        data_o = {2{wdata_i[15:0]}};
      end
      SIZE_W: begin
        be_o   = 4'b1111;
        data_o = wdata_i;
      end
      default: begin
        be_o   = 4'b0000;
        data_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a variable-latency data memory.
// Holds the pipeline while a request is outstanding, returns load data shifted
// down to byte 0, and reports misaligned accesses and bus timeouts.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        i_valid,
  input  logic        i_write,
  input  logic [1:0]  i_memSize,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_accessFault,
  output logic [31:0] o_badAddr,
  output logic        o_memReq,
  output logic        o_memWe,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWdata,
  output logic [3:0]  o_memBe,
  input  logic        i_memAck,
  input  logic [31:0] i_memRdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e         state_q, state_d;
  logic [31:0]        addr_q;
  logic               we_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fault_q;

  logic               misaligned;
  logic               startAccess;
  logic [CNT_W-1:0]   cntNext;
  logic               timeoutHit;
  logic [3:0]         alignBe;
  logic [31:0]        alignData;

  assign misaligned  = isMisaligned(i_memSize, i_addr[1:0]);
  assign startAccess = (state_q == IDLE) && i_valid && !misaligned;
  assign cntNext     = cnt_q + 1'b1;
  assign timeoutHit  = (cntNext == CNT_W'(TIMEOUT));

  store_align u_storeAlign (
    .size_i   (i_memSize),
    .addrLo_i (i_addr[1:0]),
    .wdata_i  (i_wdata),
    .be_o     (alignBe),
    .data_o   (alignData)
  );

  // State register
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: an ack beats a timeout landing in the same cycle, RESP lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startAccess) state_d = BUSY;
      BUSY:    if (i_memAck || timeoutHit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request on entry to BUSY, then count cycles and capture the ack
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startAccess) begin
            addr_q  <= i_addr;
            we_q    <= i_write;
            be_q    <= i_write ? alignBe : 4'hF;
            wdata_q <= i_write ? alignData : 32'h0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
          end
        end
        BUSY: begin
          cnt_q <= cntNext;
          if (i_memAck) begin
            if (!we_q) rdata_q <= i_memRdata >> {addr_q[1:0], 3'b000};
          end else if (timeoutHit) begin
            fault_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: stall and misalignment react to the MEM-stage op in the same cycle
  always_comb begin
    o_stall       = startAccess || (state_q == BUSY);
    o_misaligned  = (state_q == IDLE) && i_valid && misaligned;
    o_memReq      = (state_q == BUSY);
    o_accessFault = (state_q == RESP) && fault_q;
    o_badAddr     = 32'h0;
    if (o_misaligned)       o_badAddr = i_addr;
    else if (o_accessFault) o_badAddr = addr_q;
  end

  assign o_memWe    = we_q;
  assign o_memAddr  = {addr_q[31:2], 2'b00};
  assign o_memWdata = wdata_q;
  assign o_memBe    = be_q;
  assign o_rdata    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// accesses checked against a behavioural model of the unit's rules.
module tb_load_store_unit;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        reset_x;
  logic        i_valid;
  logic        i_write;
  logic [1:0]  i_memSize;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_accessFault;
  logic [31:0] o_badAddr;
  logic        o_memReq;
  logic        o_memWe;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWdata;
  logic [3:0]  o_memBe;
  logic        i_memAck;
  logic [31:0] i_memRdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expRdata = 32'h0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset_x       (reset_x),
    .i_valid       (i_valid),
    .i_write       (i_write),
    .i_memSize     (i_memSize),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .o_stall       (o_stall),
    .o_rdata       (o_rdata),
    .o_misaligned  (o_misaligned),
    .o_accessFault (o_accessFault),
    .o_badAddr     (o_badAddr),
    .o_memReq      (o_memReq),
    .o_memWe       (o_memWe),
    .o_memAddr     (o_memAddr),
    .o_memWdata    (o_memWdata),
    .o_memBe       (o_memBe),
    .i_memAck      (i_memAck),
    .i_memRdata    (i_memRdata)
  );

  // Free-running clock, rising edge active
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: alignment rule stated as "address must be a multiple of the access size"
  function automatic bit modelMisaligned(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd3) return 1'b1;
    return (addr % (32'd1 << sz)) != 0;
  endfunction

  // Model: byte enables and lane data as arithmetic on the byte offset
  task automatic modelLanes(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [3:0] be, output logic [31:0] lane);
    int off;
    off = int'(addr % 4);
    be = 4'hF;
    lane = wd;
    if (wr && sz == 2'd0) begin
      be   = 4'(1 << off);
      lane = (wd & 32'hFF) * 32'h01010101;
    end else if (wr && sz == 2'd1) begin
      be   = (off >= 2) ? 4'hC : 4'h3;
      lane = (wd & 32'hFFFF) * 32'h00010001;
    end
  endtask

  // Idle MEM cycle, optionally with a stray ack that must be ignored
  task automatic applyStimulus(input logic strayAck);
    @(negedge clk);
    i_valid    = 1'b0;
    i_memAck   = strayAck;
    i_memRdata = $urandom;
    #1;
    checkOutput("idle_stall", 32'(o_stall), 32'd0);
    checkOutput("idle_req", 32'(o_memReq), 32'd0);
    checkOutput("idle_rdata", o_rdata, expRdata);
  endtask

  // One MEM-stage op from presentation through RESP; ackAt > TIMEOUT means no ack
  task automatic doAccess(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int ackAt, input logic [31:0] rd);
    logic [3:0]  eBe;
    logic [31:0] eLane;
    int          stallCnt;
    int          reqCnt;
    bit          fault;
    int          busyCycles;
    modelLanes(wr, sz, addr, wd, eBe, eLane);
    @(negedge clk);
    i_valid    = 1'b1;
    i_write    = wr;
    i_memSize  = sz;
    i_addr     = addr;
    i_wdata    = wd;
    i_memAck   = 1'($urandom % 2);
    i_memRdata = $urandom;
    #1;
    if (modelMisaligned(sz, addr)) begin
      checkOutput("mis_flag", 32'(o_misaligned), 32'd1);
      checkOutput("mis_badaddr", o_badAddr, addr);
      checkOutput("mis_stall", 32'(o_stall), 32'd0);
      checkOutput("mis_req", 32'(o_memReq), 32'd0);
      @(negedge clk);
      i_valid  = 1'b0;
      i_memAck = 1'b0;
      #1;
      checkOutput("mis_req_after", 32'(o_memReq), 32'd0);
      checkOutput("mis_rdata", o_rdata, expRdata);
      return;
    end
    checkOutput("c0_stall", 32'(o_stall), 32'd1);
    checkOutput("c0_mis", 32'(o_misaligned), 32'd0);
    checkOutput("c0_req", 32'(o_memReq), 32'd0);
    stallCnt = 32'(o_stall);
    reqCnt   = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      i_memAck = 1'b0;
      #1;
      stallCnt += 32'(o_stall);
      reqCnt   += 32'(o_memReq);
      checkOutput("busy_req", 32'(o_memReq), 32'd1);
      checkOutput("busy_addr", o_memAddr, addr - (addr % 4));
      checkOutput("busy_be", 32'(o_memBe), 32'(eBe));
      checkOutput("busy_we", 32'(o_memWe), 32'(wr));
      if (wr) checkOutput("busy_wdata", o_memWdata, eLane);
      if (k == ackAt) begin
        i_memAck   = 1'b1;
        i_memRdata = rd;
        break;
      end
    end
    @(negedge clk);
    i_memAck   = 1'b0;
    i_memRdata = $urandom;
    #1;
    fault = ackAt > TIMEOUT;
    busyCycles = fault ? TIMEOUT : ackAt;
    if (!fault && !wr) expRdata = rd >> (8 * (addr % 4));
    stallCnt += 32'(o_stall);
    checkOutput("resp_stall", 32'(o_stall), 32'd0);
    checkOutput("resp_req", 32'(o_memReq), 32'd0);
    checkOutput("resp_fault", 32'(o_accessFault), 32'(fault));
    checkOutput("resp_badaddr", o_badAddr, fault ? addr : 32'h0);
    checkOutput("resp_rdata", o_rdata, expRdata);
    checkOutput("stall_cycles", 32'(stallCnt), 32'(busyCycles + 1));
    checkOutput("req_cycles", 32'(reqCnt), 32'(busyCycles));
  endtask

  initial begin
    reset_x    = 1'b0;
    i_valid    = 1'b0;
    i_write    = 1'b0;
    i_memSize  = 2'd0;
    i_addr     = 32'h0;
    i_wdata    = 32'h0;
    i_memAck   = 1'b0;
    i_memRdata = 32'h0;

    // Outputs while held in reset
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", 32'(o_memReq), 32'd0);
    checkOutput("rst_stall", 32'(o_stall), 32'd0);
    checkOutput("rst_rdata", o_rdata, 32'h0);
    checkOutput("rst_addr", o_memAddr, 32'h0);
    checkOutput("rst_be", 32'(o_memBe), 32'd0);
    @(negedge clk);
    reset_x = 1'b1;

    // Directed: sw, sb, lh with late ack, misaligned lw, timeout, ack on last cycle
    doAccess(1'b1, 2'd2, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h0);
    doAccess(1'b1, 2'd0, 32'h0000_1003, 32'h0000_0012, 1, 32'h0);
    applyStimulus(1'b0);
    doAccess(1'b0, 2'd1, 32'h0000_2002, 32'h0, 3, 32'hABCD_1234);
    checkOutput("lh_value", o_rdata, 32'h0000_ABCD);
    doAccess(1'b0, 2'd2, 32'h0000_2001, 32'h0, 1, 32'h0);
    doAccess(1'b0, 2'd2, 32'h0000_4008, 32'h0, TIMEOUT + 1, 32'h0);
    doAccess(1'b0, 2'd2, 32'h0000_4008, 32'h0, TIMEOUT, 32'h1357_9BDF);
    applyStimulus(1'b1);

    // Random accesses, sometimes back to back, sometimes with stray acks between
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  sz;
      logic [31:0] addr;
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz == 2'd2) addr[1:0] = 2'b00;
      end
      doAccess(1'($urandom % 2), sz, addr, $urandom, $urandom_range(1, TIMEOUT + 1), $urandom);
      if ($urandom % 2 == 0) applyStimulus(1'($urandom % 2));
    end

    // Reset asserted while a request is on the bus
    @(negedge clk);
    i_valid   = 1'b1;
    i_write   = 1'b1;
    i_memSize = 2'd2;
    i_addr    = 32'h0000_3000;
    i_wdata   = 32'hCAFE_F00D;
    i_memAck  = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("pre_rst_req", 32'(o_memReq), 32'd1);
    i_valid = 1'b0;
    reset_x = 1'b0;
    #1;
    expRdata = 32'h0;
    checkOutput("midrst_req", 32'(o_memReq), 32'd0);
    checkOutput("midrst_stall", 32'(o_stall), 32'd0);
    checkOutput("midrst_we", 32'(o_memWe), 32'd0);
    checkOutput("midrst_addr", o_memAddr, 32'h0);
    checkOutput("midrst_wdata", o_memWdata, 32'h0);
    checkOutput("midrst_be", 32'(o_memBe), 32'd0);
    checkOutput("midrst_rdata", o_rdata, 32'h0);
    checkOutput("midrst_fault", 32'(o_accessFault), 32'd0);
    checkOutput("midrst_badaddr", o_badAddr, 32'h0);
    checkOutput("midrst_mis", 32'(o_misaligned), 32'd0);
    @(negedge clk);
    reset_x = 1'b1;
    applyStimulus(1'b1);
    doAccess(1'b0, 2'd0, 32'h0000_5003, 32'h0, 2, 32'h8877_6655);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
